csr_decoder: RTL

CSR_DECODER -- requirements
Module: csr_decoder

---
 rtl/csr_pkg.sv | 17 +
 rtl/csr_entry_fifo.sv | 78 +++++++
 rtl/csr_decoder.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/csr_pkg.sv
// Shared types and default geometry for the sparse-to-dense CSR image decoder.
package csr_pkg;

    localparam int COL_LENGTH         = 8;
    localparam int WORD_LENGTH        = 8;
    localparam int DOUBLE_WORD_LENGTH = 16;
    localparam int IMAGE_SIZE         = 28;
    localparam int FIFO_DEPTH         = 4;
    localparam int PIXELS             = IMAGE_SIZE * IMAGE_SIZE;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/csr_entry_fifo.sv
// Small circular buffer holding {linear index, value} entries ahead of the pixel walker.
module csr_entry_fifo #(
    parameter int width      = 24,
    parameter int fifo_depth = 4
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             push,
    input  logic                             pop,
    input  logic                             flush,
    input  logic [width-1:0]                 wdata,
    output logic [width-1:0]                 rdata,
    output logic                             full,
    output logic                             empty,
    output logic [$clog2(fifo_depth+1)-1:0]  count_next
);

    localparam int AW = (fifo_depth > 1) ? $clog2(fifo_depth) : 1;
    localparam int CW = $clog2(fifo_depth + 1);
    localparam logic [AW-1:0] LAST_PTR = AW'(fifo_depth - 1);

    logic [width-1:0] mem_q [fifo_depth];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             push_s, pop_s;

    assign full       = (count_q == CW'(fifo_depth));
    assign empty      = (count_q == {CW{1'b0}});
    assign rdata      = mem_q[rd_ptr_q];
    assign push_s     = push && !full && !flush;
    assign pop_s      = pop && !empty && !flush;
    assign count_next = count_d;

    // Next pointer/occupancy; flush discards everything at once.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = {AW{1'b0}};
            rd_ptr_d = {AW{1'b0}};
            count_d  = {CW{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_d = (wr_ptr_q == LAST_PTR) ? {AW{1'b0}} : wr_ptr_q + AW'(1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_s) begin
                rd_ptr_d = (rd_ptr_q == LAST_PTR) ? {AW{1'b0}} : rd_ptr_q + AW'(1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            count_d = count_q + CW'(push_s) - CW'(pop_s);
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= {AW{1'b0}};
            rd_ptr_q <= {AW{1'b0}};
            count_q  <= {CW{1'b0}};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage needs no reset: occupancy gates every read.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

endmodule

// File: rtl/csr_decoder.sv
// Expands a stream of (row, col, value) nonzero entries into a dense raster of
// image_size*image_size pixels, filling gaps with zeros and dropping misordered entries.
module csr_decoder
    import csr_pkg::*;
#(
    parameter int col_length         = COL_LENGTH,
    parameter int word_length        = WORD_LENGTH,
    parameter int double_word_length = DOUBLE_WORD_LENGTH,
    parameter int image_size         = IMAGE_SIZE,
    parameter int fifo_depth         = FIFO_DEPTH
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [double_word_length-1:0] nnz,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [word_length-1:0]        in_value,
    input  logic [col_length-1:0]         in_col,
    input  logic [col_length-1:0]         in_row,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [word_length-1:0]        out_data,
    output logic                          out_last,
    output logic                          done,
    output logic                          order_err
);

    localparam int DW = double_word_length;
    localparam int EW = DW + word_length;
    localparam int CW = $clog2(fifo_depth + 1);
    localparam logic [DW-1:0] PIX_END  = DW'(image_size * image_size);
    localparam logic [DW-1:0] PIX_LAST = DW'(image_size * image_size - 1);

    state_e                 state_q, state_d;
    logic [DW-1:0]          pix_q, pix_d, used_q, used_d, nnz_q, nnz_d;
    logic                   out_valid_q, out_valid_d, out_last_q, out_last_d;
    logic                   done_q, done_d, order_err_q, order_err_d, in_ready_q, in_ready_d;
    logic [word_length-1:0] out_data_q, out_data_d, head_val_s;
    logic [DW-1:0]          in_idx_s, head_idx_s, slot_s;
    logic [EW-1:0]          head_s;
    logic [CW-1:0]          count_next_s;
    logic                   push_s, pop_s, flush_s, discard_s, fill_s;
    logic                   out_fire_s, full_s, empty_s, quota_s;

    assign in_idx_s   = DW'(in_row) * DW'(image_size) + DW'(in_col);
    assign {head_idx_s, head_val_s} = head_s;
    // The output register holds pixel pix while valid, so the next slot is one beyond it.
    assign slot_s     = out_valid_q ? pix_q + DW'(1) : pix_q;
    assign quota_s    = (used_q >= nnz_q);
    assign out_fire_s = out_valid_q && out_ready;
    assign push_s     = in_valid && in_ready_q && !full_s && !discard_s;
    assign in_ready_d = (state_d != DONE) && (count_next_s < CW'(fifo_depth));
    assign done_d     = (state_d == DONE);

    csr_entry_fifo #(
        .width      (EW),
        .fifo_depth (fifo_depth)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (push_s),
        .pop        (pop_s),
        .flush      (flush_s),
        .wdata      ({in_idx_s, in_value}),
        .rdata      (head_s),
        .full       (full_s),
        .empty      (empty_s),
        .count_next (count_next_s)
    );

    // Per-slot decision: emit the head, emit a zero, drop a bad head, or stall.
    always_comb begin
        state_d     = state_q;
        used_d      = used_q;
        nnz_d       = nnz_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        order_err_d = order_err_q;
        pop_s       = 1'b0;
        flush_s     = 1'b0;
        discard_s   = 1'b0;
        fill_s      = 1'b0;
        if (out_fire_s) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
            pix_d       = out_last_q ? pix_q : pix_q + DW'(1);
        end else begin
            pix_d       = pix_q;
        end
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d     = SCAN;
                    nnz_d       = nnz;
                    pix_d       = {DW{1'b0}};
                    used_d      = {DW{1'b0}};
                    order_err_d = 1'b0;
                end else begin
                    state_d     = IDLE;
                end
            end
            SCAN: begin
                discard_s = in_valid && in_ready_q && quota_s;
                fill_s    = !out_valid_q || (out_ready && !out_last_q);
                if (discard_s) begin
                    order_err_d = 1'b1;
                end else begin
                    order_err_d = order_err_q;
                end
                if (fill_s && !empty_s && (head_idx_s >= PIX_END || head_idx_s < slot_s)) begin
                    pop_s       = 1'b1;
                    used_d      = used_q + DW'(1);
                    order_err_d = 1'b1;
                end else if (fill_s && !empty_s && head_idx_s == slot_s) begin
                    pop_s       = 1'b1;
                    used_d      = used_q + DW'(1);
                    out_valid_d = 1'b1;
                    out_data_d  = head_val_s;
                    out_last_d  = (slot_s == PIX_LAST);
                end else if (fill_s && (!empty_s || quota_s)) begin
                    out_valid_d = 1'b1;
                    out_data_d  = {word_length{1'b0}};
                    out_last_d  = (slot_s == PIX_LAST);
                end else begin
                    pop_s       = 1'b0;
                end
                if (out_fire_s && out_last_q) begin
                    state_d = DONE;
                end else begin
                    state_d = SCAN;
                end
            end
            DONE: begin
                flush_s     = 1'b1;
                order_err_d = order_err_q | !empty_s;
                state_d     = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            pix_q       <= {DW{1'b0}};
            used_q      <= {DW{1'b0}};
            nnz_q       <= {DW{1'b0}};
            out_valid_q <= 1'b0;
            out_data_q  <= {word_length{1'b0}};
            out_last_q  <= 1'b0;
            done_q      <= 1'b0;
            order_err_q <= 1'b0;
            in_ready_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            pix_q       <= pix_d;
            used_q      <= used_d;
            nnz_q       <= nnz_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            done_q      <= done_d;
            order_err_q <= order_err_d;
            in_ready_q  <= in_ready_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
    assign done      = done_q;
    assign order_err = order_err_q;

endmodule
